rr_arbiter_4: RTL and testbench

- Four-requester round-robin arbiter. It shares one resource that is selected through the 2-to-4 one-hot decoder path.
- It produces a registered 2-bit grant index plus a grant-valid. These map directly onto the decoder's select/enable pair (I/En).
- It also produces the equivalent one-hot grant vector.
- A hold timeout stops a single requester from monopolising the resource while others wait.

---
 rtl/rr_arbiter_4.sv | 94 +++++++++
 tb/tb_rr_arbiter_4.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot and binary grants
// and a hold timeout that forces rotation once another requester is waiting.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_vld,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] owner_oh;
  logic [3:0] others;
  logic [1:0] after_idx;
  logic [1:0] first_sel;
  logic [1:0] next_sel;
  logic       hold_limit;
  logic       handoff;

  // First set bit of r scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  function automatic logic [3:0] dec(input logic [1:0] idx);
    dec = 4'b0001 << idx;
  endfunction

  always_comb begin
    owner_oh   = dec(gnt_idx);
    others     = req & ~owner_oh;
    after_idx  = gnt_idx + 2'd1;
    first_sel  = pick(req, ptr);
    next_sel   = pick(others, after_idx);
    // Compared with >= so a competitor arriving after saturation still preempts.
    hold_limit = (MAX_HOLD != 0) && (hold_cnt >= CNT_W'(MAX_HOLD));
    handoff    = !req[gnt_idx] || (hold_limit && (|others));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'd0;
      gnt_vld  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            gnt_idx  <= first_sel;
            gnt_vld  <= 1'b1;
            gnt      <= dec(first_sel);
            hold_cnt <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (handoff) begin
            ptr <= after_idx;
            if (|others) begin
              gnt_idx  <= next_sel;
              gnt      <= dec(next_sel);
              hold_cnt <= CNT_W'(1);
            end else begin
              state    <= IDLE;
              gnt_vld  <= 1'b0;
              gnt      <= 4'b0000;
              hold_cnt <= '0;
            end
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4 (MAX_HOLD = 4): directed vector table, hand sequences
// for saturation and mid-grant reset, then a random run against a small model.
module tb_rr_arbiter_4;

  localparam int MAXH = 4;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = 4'b0000;
  logic [3:0]    gnt;
  logic [1:0]    gnt_idx;
  logic          gnt_vld;
  logic [CW-1:0] hold_cnt;

  int total = 0;
  int bad   = 0;

  rr_arbiter_4 #(.MAX_HOLD(MAXH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic [3:0] hold;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] i, input logic v, input logic [3:0] h);
    vec_t e;
    e.rst = r; e.req = q; e.gnt = g; e.idx = i; e.vld = v; e.hold = h;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample outputs just after the rising edge.
  task automatic cycle(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string tag, input vec_t e);
    cycle(e.rst, e.req);
    check({tag, " gnt"},  32'(gnt),      32'(e.gnt));
    check({tag, " idx"},  32'(gnt_idx),  32'(e.idx));
    check({tag, " vld"},  32'(gnt_vld),  32'(e.vld));
    check({tag, " hold"}, 32'(hold_cnt), 32'(e.hold));
  endtask

  // Reference model state for the random run.
  logic       m_vld;
  logic [1:0] m_idx;
  logic [1:0] m_ptr;
  int         m_cnt;

  function automatic logic [1:0] first_from(input logic [3:0] r, input logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      if (r[(int'(p) + k) % 4]) return 2'((int'(p) + k) % 4);
    end
    return p;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q);
    logic [3:0] oth;
    if (r) begin
      m_vld = 1'b0; m_idx = 2'd0; m_ptr = 2'd0; m_cnt = 0;
    end else if (!m_vld) begin
      if (q != 4'b0000) begin
        m_idx = first_from(q, m_ptr); m_vld = 1'b1; m_cnt = 1;
      end
    end else begin
      oth = q;
      oth[m_idx] = 1'b0;
      if (!q[m_idx] || (m_cnt >= MAXH && oth != 4'b0000)) begin
        m_ptr = m_idx + 2'd1;
        if (oth != 4'b0000) begin
          m_idx = first_from(oth, m_ptr); m_cnt = 1;
        end else begin
          m_vld = 1'b0; m_cnt = 0;
        end
      end else if (m_cnt < 15) begin
        m_cnt++;
      end
    end
  endtask

  initial begin
    vec_t e;
    logic [3:0] rq;
    logic       rr;
    logic [3:0] exp_g;
    int         wait_cnt[4];

    // Reset, single request, release, idle.
    add(1, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);
    add(1, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);
    add(0, 4'b0010, 4'b0010, 2'd1, 1, 4'd1);
    add(0, 4'b0000, 4'b0000, 2'd1, 0, 4'd0);
    add(0, 4'b0000, 4'b0000, 2'd1, 0, 4'd0);
    // Fairness: all request, each owner drops for one cycle after three.
    add(1, 4'b1111, 4'b0000, 2'd0, 0, 4'd0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1, 4'd1);
    add(0, 4'b1111, 4'b0001, 2'd0, 1, 4'd2);
    add(0, 4'b1111, 4'b0001, 2'd0, 1, 4'd3);
    add(0, 4'b1110, 4'b0010, 2'd1, 1, 4'd1);
    add(0, 4'b1111, 4'b0010, 2'd1, 1, 4'd2);
    add(0, 4'b1111, 4'b0010, 2'd1, 1, 4'd3);
    add(0, 4'b1101, 4'b0100, 2'd2, 1, 4'd1);
    add(0, 4'b1111, 4'b0100, 2'd2, 1, 4'd2);
    add(0, 4'b1111, 4'b0100, 2'd2, 1, 4'd3);
    add(0, 4'b1011, 4'b1000, 2'd3, 1, 4'd1);
    add(0, 4'b1111, 4'b1000, 2'd3, 1, 4'd2);
    add(0, 4'b1111, 4'b1000, 2'd3, 1, 4'd3);
    add(0, 4'b0111, 4'b0001, 2'd0, 1, 4'd1);
    // Wrap-around: owner 3 releases with 0011 waiting -> 0 wins.
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 4'd1);
    add(0, 4'b0011, 4'b0001, 2'd0, 1, 4'd1);
    // Timeout preemption after four cycles of ownership.
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);
    add(0, 4'b0001, 4'b0001, 2'd0, 1, 4'd1);
    add(0, 4'b0101, 4'b0001, 2'd0, 1, 4'd2);
    add(0, 4'b0101, 4'b0001, 2'd0, 1, 4'd3);
    add(0, 4'b0101, 4'b0001, 2'd0, 1, 4'd4);
    add(0, 4'b0101, 4'b0100, 2'd2, 1, 4'd1);
    add(0, 4'b0000, 4'b0000, 2'd2, 0, 4'd0);
    add(0, 4'b0001, 4'b0001, 2'd0, 1, 4'd1);

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Lone owner keeps the grant and the counter saturates at 15.
    for (int k = 2; k <= 17; k++) begin
      e.rst = 0; e.req = 4'b0001; e.gnt = 4'b0001; e.idx = 2'd0; e.vld = 1;
      e.hold = (k > 15) ? 4'd15 : 4'(k);
      apply($sformatf("sat%0d", k), e);
    end
    // Competitor after saturation is granted on the next edge.
    e.req = 4'b0011; e.gnt = 4'b0010; e.idx = 2'd1; e.hold = 4'd1;
    apply("sat_preempt", e);

    // Mid-grant reset: ptr is 2 before reset, must restart at 0.
    e.rst = 0; e.req = 4'b0000; e.gnt = 4'b0000; e.idx = 2'd1; e.vld = 0; e.hold = 4'd0;
    apply("mr_release", e);
    e.req = 4'b1000; e.gnt = 4'b1000; e.idx = 2'd3; e.vld = 1; e.hold = 4'd1;
    apply("mr_grant3", e);
    e.rst = 1; e.req = 4'b1111; e.gnt = 4'b0000; e.idx = 2'd0; e.vld = 0; e.hold = 4'd0;
    apply("mr_reset", e);
    e.rst = 0; e.gnt = 4'b0001; e.vld = 1; e.hold = 4'd1;
    apply("mr_after", e);

    // Random run against the model with invariant and starvation checks.
    cycle(1'b1, 4'b0000);
    model_step(1'b1, 4'b0000);
    for (int j = 0; j < 4; j++) wait_cnt[j] = 0;
    rq = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 999) == 0);
      cycle(rr, rq);
      model_step(rr, rq);
      exp_g = m_vld ? (4'b0001 << m_idx) : 4'b0000;
      check("rnd onehot", 32'($countones(gnt) <= 1), 32'd1);
      check("rnd decode", 32'(gnt), 32'(gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000));
      check("rnd gnt",  32'(gnt), 32'(exp_g));
      check("rnd vld",  32'(gnt_vld), 32'(m_vld));
      check("rnd hold", 32'(hold_cnt), 32'(m_cnt));
      for (int j = 0; j < 4; j++) begin
        if (!rr && rq[j] && !gnt[j]) wait_cnt[j]++;
        else wait_cnt[j] = 0;
        if (wait_cnt[j] > 3 * MAXH + 3) begin
          check($sformatf("starve%0d", j), 32'(wait_cnt[j]), 32'(3 * MAXH + 3));
          wait_cnt[j] = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
